// File: rtl/mshr_arbiter_pkg.sv
// Shared widths and the CHI request payload for the MSHR arbiter slice.
package mshr_arbiter_pkg;

  localparam int unsigned MSHR_NUM_DEF     = 4;
  localparam int unsigned MSHR_NUM_LOG_DEF = 2;
  localparam int unsigned PADDR_W          = 40;
  localparam int unsigned LINE_W           = 512;

  // One CHI read request: line address plus originating entry as txnid.
  typedef struct packed {
    logic [PADDR_W-1:0]          paddr;
    logic [MSHR_NUM_LOG_DEF-1:0] txnid;
  } chi_req_t;

endpackage

// File: rtl/mshr_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Ports: req (request vector), ptr (start index),
//        grant_c (one-hot), idx_c (grant index), any_c (some request present).
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_c,
  output logic [W-1:0] idx_c,
  output logic         any_c
);

  // Upper pass covers [ptr, N-1], lower pass covers the wrap [0, ptr-1].
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any_c && req[j] && (W'(j) >= ptr)) begin
        grant_c[j] = 1'b1;
        idx_c      = W'(j);
        any_c      = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!any_c && req[j] && (W'(j) < ptr)) begin
        grant_c[j] = 1'b1;
        idx_c      = W'(j);
        any_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mshr_arbiter.sv
// MSHR arbiter: round-robins entry misses onto the CHI request channel,
// tracks one outstanding transaction per entry, routes CHI responses back
// by txnid, and round-robins the dcache refill port.
// Ports:
//   clock, reset                    - clock, async active-high reset
//   entry_req_valid/paddr/ready     - per-entry miss requests, one-hot accept
//   chi_req_valid/ready/paddr/txnid - CHI request channel (registered stage)
//   chi_resp_valid/txnid/data       - CHI data response
//   entry_resp_valid/data           - one-hot delivery, broadcast line data
//   entry_rdy2refill, refill_ready  - refill candidates, refill port free
//   win_refill_arb                  - registered one-hot refill grant
//   resp_err                        - pulse for response to non-outstanding id
module mshr_arbiter
  import mshr_arbiter_pkg::*;
#(
  parameter int unsigned MSHR_NUM     = MSHR_NUM_DEF,
  parameter int unsigned MSHR_NUM_LOG = MSHR_NUM_LOG_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MSHR_NUM-1:0]         entry_req_valid,
  input  logic [MSHR_NUM*PADDR_W-1:0] entry_req_paddr,
  output logic [MSHR_NUM-1:0]         entry_req_ready,
  output logic                        chi_req_valid,
  input  logic                        chi_req_ready,
  output logic [PADDR_W-1:0]          chi_req_paddr,
  output logic [MSHR_NUM_LOG-1:0]     chi_req_txnid,
  input  logic                        chi_resp_valid,
  input  logic [MSHR_NUM_LOG-1:0]     chi_resp_txnid,
  input  logic [LINE_W-1:0]           chi_resp_data,
  output logic [MSHR_NUM-1:0]         entry_resp_valid,
  output logic [LINE_W-1:0]           entry_resp_data,
  input  logic [MSHR_NUM-1:0]         entry_rdy2refill,
  input  logic                        refill_ready,
  output logic [MSHR_NUM-1:0]         win_refill_arb,
  output logic                        resp_err
);

  logic                    stage_valid_q, stage_valid_d;
  chi_req_t                stage_q, stage_d;
  logic [MSHR_NUM-1:0]     outstanding_q, outstanding_d;
  logic [MSHR_NUM-1:0]     win_refill_arb_q, win_refill_arb_d;
  logic [MSHR_NUM_LOG-1:0] req_ptr_q, req_ptr_d;
  logic [MSHR_NUM_LOG-1:0] refill_ptr_q, refill_ptr_d;
  logic                    resp_err_q, resp_err_d;

  logic [MSHR_NUM-1:0]     eligible_c, req_grant_c, resp_dec_c;
  logic [MSHR_NUM-1:0]     refill_cand_c, refill_grant_c;
  logic [MSHR_NUM_LOG-1:0] req_idx_c, refill_idx_c;
  logic                    req_any_c, refill_any_c;
  logic                    hs_c, load_c, resp_hit_c, refill_fire_c;
  logic [PADDR_W-1:0]      sel_paddr_c;

  function automatic logic [MSHR_NUM_LOG-1:0] ptr_inc(input logic [MSHR_NUM_LOG-1:0] idx);
    return (idx == MSHR_NUM_LOG'(MSHR_NUM - 1)) ? '0 : idx + MSHR_NUM_LOG'(1);
  endfunction

  // Eligibility excludes entries already in flight or sitting in the stage.
  always_comb begin
    eligible_c = '0;
    resp_dec_c = '0;
    for (int unsigned i = 0; i < MSHR_NUM; i++) begin
      eligible_c[i] = entry_req_valid[i] & ~outstanding_q[i] &
                      ~(stage_valid_q & (stage_q.txnid == MSHR_NUM_LOG'(i)));
      resp_dec_c[i] = chi_resp_valid & outstanding_q[i] &
                      (chi_resp_txnid == MSHR_NUM_LOG'(i));
    end
    resp_hit_c = |resp_dec_c;
  end

  rr_arbiter #(.N(MSHR_NUM), .W(MSHR_NUM_LOG)) u_req_rr (
    .req     (eligible_c),
    .ptr     (req_ptr_q),
    .grant_c (req_grant_c),
    .idx_c   (req_idx_c),
    .any_c   (req_any_c)
  );

  // Masking last cycle's winner covers the cycle its rdy2refill is still falling.
  assign refill_cand_c = entry_rdy2refill & ~win_refill_arb_q;

  rr_arbiter #(.N(MSHR_NUM), .W(MSHR_NUM_LOG)) u_refill_rr (
    .req     (refill_cand_c),
    .ptr     (refill_ptr_q),
    .grant_c (refill_grant_c),
    .idx_c   (refill_idx_c),
    .any_c   (refill_any_c)
  );

  // Address of the winning entry.
  always_comb begin
    sel_paddr_c = '0;
    for (int unsigned i = 0; i < MSHR_NUM; i++) begin
      if (req_grant_c[i]) sel_paddr_c = entry_req_paddr[i*PADDR_W +: PADDR_W];
    end
  end

  // Next-state for stage, outstanding set, pointers and registered pulses.
  always_comb begin
    stage_valid_d    = stage_valid_q;
    stage_d          = stage_q;
    req_ptr_d        = req_ptr_q;
    refill_ptr_d     = refill_ptr_q;
    win_refill_arb_d = '0;
    outstanding_d    = outstanding_q & ~resp_dec_c;

    hs_c          = stage_valid_q & chi_req_ready;
    load_c        = (~stage_valid_q | chi_req_ready) & req_any_c;
    refill_fire_c = refill_ready & refill_any_c;

    if (load_c) begin
      stage_valid_d = 1'b1;
      stage_d.paddr = sel_paddr_c;
      stage_d.txnid = req_idx_c;
      req_ptr_d     = ptr_inc(req_idx_c);
    end else if (hs_c) begin
      stage_valid_d = 1'b0;
    end

    // A handshaking id is never outstanding, so set and clear never collide.
    if (hs_c) outstanding_d = outstanding_d | (MSHR_NUM'(1) << stage_q.txnid);

    if (refill_fire_c) begin
      win_refill_arb_d = refill_grant_c;
      refill_ptr_d     = ptr_inc(refill_idx_c);
    end

    resp_err_d = chi_resp_valid & ~resp_hit_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid_q    <= 1'b0;
      stage_q          <= '0;
      outstanding_q    <= '0;
      req_ptr_q        <= '0;
      refill_ptr_q     <= '0;
      win_refill_arb_q <= '0;
      resp_err_q       <= 1'b0;
    end else begin
      stage_valid_q    <= stage_valid_d;
      stage_q          <= stage_d;
      outstanding_q    <= outstanding_d;
      req_ptr_q        <= req_ptr_d;
      refill_ptr_q     <= refill_ptr_d;
      win_refill_arb_q <= win_refill_arb_d;
      resp_err_q       <= resp_err_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign entry_req_ready  = (load_c & ~reset) ? req_grant_c : '0;
  assign entry_resp_valid = resp_dec_c;
  assign entry_resp_data  = reset ? '0 : chi_resp_data;
  assign chi_req_valid    = stage_valid_q;
  assign chi_req_paddr    = stage_q.paddr;
  assign chi_req_txnid    = stage_q.txnid;
  assign win_refill_arb   = win_refill_arb_q;
  assign resp_err         = resp_err_q;

endmodule

// File: tb/tb_mshr_arbiter.sv
// Scoreboard bench for mshr_arbiter: expected CHI requests are queued by the
// stimulus and popped by a monitor on every request handshake.
module tb_mshr_arbiter;
  import mshr_arbiter_pkg::*;

  localparam int unsigned N  = MSHR_NUM_DEF;
  localparam int unsigned TW = MSHR_NUM_LOG_DEF;
  localparam int unsigned PW = PADDR_W;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [N-1:0]          entry_req_valid;
  logic [N*PW-1:0]       entry_req_paddr;
  logic [N-1:0]          entry_req_ready;
  logic                  chi_req_valid;
  logic                  chi_req_ready;
  logic [PW-1:0]         chi_req_paddr;
  logic [TW-1:0]         chi_req_txnid;
  logic                  chi_resp_valid;
  logic [TW-1:0]         chi_resp_txnid;
  logic [LINE_W-1:0]     chi_resp_data;
  logic [N-1:0]          entry_resp_valid;
  logic [LINE_W-1:0]     entry_resp_data;
  logic [N-1:0]          entry_rdy2refill;
  logic                  refill_ready;
  logic [N-1:0]          win_refill_arb;
  logic                  resp_err;

  mshr_arbiter #(.MSHR_NUM(N), .MSHR_NUM_LOG(TW)) dut (
    .clock            (clock),
    .reset            (reset),
    .entry_req_valid  (entry_req_valid),
    .entry_req_paddr  (entry_req_paddr),
    .entry_req_ready  (entry_req_ready),
    .chi_req_valid    (chi_req_valid),
    .chi_req_ready    (chi_req_ready),
    .chi_req_paddr    (chi_req_paddr),
    .chi_req_txnid    (chi_req_txnid),
    .chi_resp_valid   (chi_resp_valid),
    .chi_resp_txnid   (chi_resp_txnid),
    .chi_resp_data    (chi_resp_data),
    .entry_resp_valid (entry_resp_valid),
    .entry_resp_data  (entry_resp_data),
    .entry_rdy2refill (entry_rdy2refill),
    .refill_ready     (refill_ready),
    .win_refill_arb   (win_refill_arb),
    .resp_err         (resp_err)
  );

  always #5 clock = ~clock;

  int       checks = 0;
  int       errors = 0;
  chi_req_t exp_q[$];
  chi_req_t mon_e;
  int       order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [LINE_W-1:0] d_a5 = {64{8'hA5}};
  logic [LINE_W-1:0] d_3c = {64{8'h3C}};

  function automatic logic [PW-1:0] pa(input int i);
    return PW'(64'h2000 + 64'(i) * 64'h40);
  endfunction

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [PW-1:0] a, input int id);
    chi_req_t e;
    e.paddr = a;
    e.txnid = TW'(id);
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  // Monitor: every request handshake must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && chi_req_valid && chi_req_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL chi_req_unexpected: got txnid %0d paddr %0h, expected no request",
                 chi_req_txnid, chi_req_paddr);
      end else begin
        mon_e = exp_q.pop_front();
        if (chi_req_paddr !== mon_e.paddr || chi_req_txnid !== mon_e.txnid) begin
          errors++;
          $display("FAIL chi_req: got txnid %0d paddr %0h expected txnid %0d paddr %0h",
                   chi_req_txnid, chi_req_paddr, mon_e.txnid, mon_e.paddr);
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    entry_req_valid  = '0;
    entry_req_paddr  = '0;
    chi_req_ready    = 1'b0;
    chi_resp_valid   = 1'b0;
    chi_resp_txnid   = '0;
    chi_resp_data    = '0;
    entry_rdy2refill = '0;
    refill_ready     = 1'b0;

    smp();
    chk("reset_outputs", {entry_req_ready, chi_req_valid, chi_req_paddr, chi_req_txnid,
                          entry_resp_valid, win_refill_arb, resp_err}, '0);
    nxt();
    reset = 1'b0;

    // Single request from entry 2.
    nxt();
    entry_req_paddr[2*PW +: PW] = PW'(40'h1000);
    entry_req_valid = 4'b0100;
    chi_req_ready   = 1'b1;
    push_req(PW'(40'h1000), 2);
    smp();
    chk("single_grant", entry_req_ready, 4'b0100);
    chk("single_no_valid_t", chi_req_valid, 1'b0);
    nxt();
    entry_req_valid = '0;
    smp();
    chk("single_valid_t1", chi_req_valid, 1'b1);
    chk("single_no_regrant", entry_req_ready, '0);
    nxt();
    chi_resp_valid = 1'b1;
    chi_resp_txnid = 2'd2;
    chi_resp_data  = d_3c;
    smp();
    chk("single_resp", entry_resp_valid, 4'b0100);
    chk("single_resp_data", entry_resp_data, d_3c);
    nxt();
    chi_resp_valid = 1'b0;
    smp();
    chk("single_no_err", resp_err, 1'b0);

    // Reset pulse so fairness starts from pointer 0.
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;

    // Fairness: everyone requests, each response one cycle after handshake.
    for (int i = 0; i < int'(N); i++) entry_req_paddr[i*PW +: PW] = pa(i);
    for (int k = 0; k < 10; k++) begin
      nxt();
      entry_req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      chi_resp_valid  = (k >= 2);
      chi_resp_txnid  = (k >= 2) ? TW'(order[(k >= 2) ? k - 2 : 0]) : '0;
      if (k < 8) push_req(pa(order[k]), order[k]);
      smp();
      if (k < 8) chk("fair_grant", entry_req_ready, N'(1) << order[k]);
      else       chk("fair_idle", entry_req_ready, '0);
      if (k >= 2) chk("fair_resp", entry_resp_valid, N'(1) << order[k - 2]);
    end
    nxt();
    chi_resp_valid  = 1'b0;
    entry_req_valid = '0;

    // Backpressure: stage holds entry 0 for five cycles, entry 1 waits.
    nxt();
    chi_req_ready   = 1'b0;
    entry_req_valid = 4'b0011;
    push_req(pa(0), 0);
    smp();
    chk("bp_grant0", entry_req_ready, 4'b0001);
    nxt();
    entry_req_valid = 4'b0010;
    for (int b = 0; b < 5; b++) begin
      if (b > 0) nxt();
      smp();
      chk("bp_hold", {chi_req_valid, chi_req_paddr, chi_req_txnid, entry_req_ready},
          {1'b1, pa(0), TW'(0), N'(0)});
    end
    nxt();
    chi_req_ready = 1'b1;
    push_req(pa(1), 1);
    smp();
    chk("bp_release_grant", entry_req_ready, 4'b0010);
    nxt();
    entry_req_valid = '0;
    smp();

    // Routing: outstanding {0,1}; free 0 while granting 3, leaving {1,3}.
    nxt();
    chi_resp_valid  = 1'b1;
    chi_resp_txnid  = 2'd0;
    chi_resp_data   = d_3c;
    entry_req_valid = 4'b1000;
    push_req(pa(3), 3);
    smp();
    chk("rt_resp0", entry_resp_valid, 4'b0001);
    chk("rt_grant3", entry_req_ready, 4'b1000);
    nxt();
    entry_req_valid = '0;
    chi_resp_valid  = 1'b0;
    smp();
    nxt();
    chi_resp_valid = 1'b1;
    chi_resp_txnid = 2'd3;
    chi_resp_data  = d_a5;
    smp();
    chk("rt_resp3", entry_resp_valid, 4'b1000);
    chk("rt_data", entry_resp_data, d_a5);
    nxt();
    chi_resp_txnid = 2'd0;
    smp();
    chk("rt_unknown_nodeliver", entry_resp_valid, '0);
    chk("rt_err_not_yet", resp_err, 1'b0);
    nxt();
    chi_resp_valid = 1'b0;
    smp();
    chk("rt_err", resp_err, 1'b1);
    nxt();
    smp();
    chk("rt_err_pulse", resp_err, 1'b0);
    nxt();
    chi_resp_valid = 1'b1;
    chi_resp_txnid = 2'd1;
    smp();
    chk("rt_resp1_kept", entry_resp_valid, 4'b0010);
    nxt();
    chi_resp_valid = 1'b0;

    // Refill round-robin.
    nxt();
    entry_rdy2refill = 4'b0110;
    refill_ready     = 1'b1;
    smp();
    chk("rf_none_yet", win_refill_arb, '0);
    nxt();
    smp();
    chk("rf_first", win_refill_arb, 4'b0010);
    nxt();
    refill_ready = 1'b0;
    smp();
    chk("rf_second", win_refill_arb, 4'b0100);
    nxt();
    smp();
    chk("rf_blocked", win_refill_arb, '0);
    nxt();
    entry_rdy2refill = '0;
    smp();
    chk("rf_blocked2", win_refill_arb, '0);

    // Reset with stage full and entries 0,1 outstanding.
    nxt();
    entry_req_valid = 4'b0001;
    chi_req_ready   = 1'b1;
    push_req(pa(0), 0);
    smp();
    chk("rs_grant0", entry_req_ready, 4'b0001);
    nxt();
    entry_req_valid = 4'b0010;
    push_req(pa(1), 1);
    smp();
    chk("rs_grant1", entry_req_ready, 4'b0010);
    nxt();
    entry_req_valid = 4'b0100;
    smp();
    chk("rs_grant2", entry_req_ready, 4'b0100);
    nxt();
    chi_req_ready    = 1'b0;
    entry_req_valid  = 4'b1111;
    entry_rdy2refill = 4'b0001;
    refill_ready     = 1'b1;
    smp();
    chk("rs_stage_full", {chi_req_valid, chi_req_txnid}, {1'b1, TW'(2)});
    nxt();
    smp();
    chk("rs_win_before", win_refill_arb, 4'b0001);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_outputs_now", {entry_req_ready, chi_req_valid, chi_req_paddr, chi_req_txnid,
                           entry_resp_valid, win_refill_arb, resp_err}, '0);
    nxt();
    smp();
    chk("rs_outputs_held", {entry_req_ready, chi_req_valid, entry_resp_valid,
                            win_refill_arb, resp_err}, '0);
    nxt();
    reset            = 1'b0;
    entry_rdy2refill = '0;
    refill_ready     = 1'b0;
    chi_resp_valid   = 1'b1;
    chi_resp_txnid   = 2'd1;
    smp();
    chk("rs_ptr_zero_grant", entry_req_ready, 4'b0001);
    chk("rs_inflight_nodeliver", entry_resp_valid, '0);
    nxt();
    chi_resp_valid  = 1'b0;
    entry_req_valid = '0;
    smp();
    chk("rs_inflight_err", resp_err, 1'b1);

    chk("queue_drained", 32'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mshr_arbiter.md
# mshr_arbiter

Shared-resource controller for the dcache MSHR file. It round-robin arbitrates the MSHR entries' miss requests onto the single CHI request channel toward L2/memory. It tracks one outstanding transaction per entry and routes CHI responses back to the owning entry by transaction id. It also round-robin grants the single dcache refill port among entries ready to refill. It sits between the MSHR entry array and the CHI/L2 interface and dcache data-array write port.

## Interface
Parameters:
- MSHR_NUM, `MSHR_NUM: number of MSHR entries.
- MSHR_NUM_LOG, `MSHR_NUM_LOG: width of entry index / CHI txnid.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- entry_req_valid  in  MSHR_NUM  per-entry miss request; held until granted
- entry_req_paddr  in  MSHR_NUM×`PADDR_RANGE  per-entry line address, packed, entry i at slice i
- entry_req_ready  out  MSHR_NUM  one-hot grant pulse, request accepted into output stage
- chi_req_valid  out  1  CHI read request valid
- chi_req_ready  in  1  CHI accepts request
- chi_req_paddr  out  `PADDR_RANGE  request line address
- chi_req_txnid  out  MSHR_NUM_LOG  originating entry index
- chi_resp_valid  in  1  CHI data response
- chi_resp_txnid  in  MSHR_NUM_LOG  response owner
- chi_resp_data  in  512  refill line
- entry_resp_valid  out  MSHR_NUM  one-hot response delivery
- entry_resp_data  out  512  chi_resp_data broadcast to all entries
- entry_rdy2refill  in  MSHR_NUM  entry holds data, wants refill port
- refill_ready  in  1  dcache refill port free this cycle
- win_refill_arb  out  MSHR_NUM  one-hot refill grant pulse
- resp_err  out  1  pulse: response for non-outstanding txnid

## Operation
- Request output stage: one register holding {valid, paddr, txnid}. Loadable when empty or when chi_req_valid & chi_req_ready in the same cycle, so back-to-back requests flow at one per cycle.
- Eligible entry i: entry_req_valid[i] & ~outstanding[i] & ~(stage valid & stage txnid==i).
- Request RR: pick the first eligible entry at or after req_ptr, wrapping modulo MSHR_NUM. On load, entry_req_ready[grant]=1 for that cycle, req_ptr ← grant+1, wrapping.
- Stage holds paddr/txnid stable while chi_req_valid & ~chi_req_ready.
- outstanding[txnid] set on CHI handshake. It is cleared on chi_resp_valid with matching txnid.
- Response routing: entry_resp_valid = chi_resp_valid & outstanding[chi_resp_txnid] decoded one-hot, combinational. Unknown txnid: no delivery, resp_err pulses the next cycle, outstanding unchanged.
- Refill RR: candidates = entry_rdy2refill & ~win_refill_arb_q, which masks last cycle's winner while its rdy2refill falls. When refill_ready & any candidate, grant the first at or after refill_ptr, refill_ptr ← grant+1.
- Simultaneous CHI handshake and response for different ids: both applied in the same cycle.

## Timing
- Reset values: all outputs 0, stage empty, outstanding=0, both pointers 0.
- Request latency: entry_req_ready in cycle t → chi_req_valid from cycle t+1.
- Minimum entry-to-entry throughput: 1 request per cycle with chi_req_ready high.
- Response: entry_resp_valid in the same cycle as chi_resp_valid. outstanding clears at the following edge, and the entry is eligible again from cycle t+1.
- Refill grant: win_refill_arb registered. A candidate in cycle t (with refill_ready) → single-cycle grant in t+1.
- Reset mid-operation: stage, outstanding, and pointers clear immediately. An in-flight CHI response after reset reports resp_err.

## Structure
- Shared package/defines: `MSHR_NUM, `MSHR_NUM_LOG, `PADDR_RANGE. Add a chi_req struct {paddr, txnid}.
- One sub-module: rr_arbiter (parameter N; inputs req and ptr; outputs one-hot grant and index), instantiated twice (request, refill).

## Test plan
- Single request, MSHR_NUM=4: entry2 valid, paddr 0x1000, ready high → entry_req_ready=4'b0100 at t, chi_req_valid/txnid=2/paddr 0x1000 at t+1.
- Fairness: all four entries request continuously, responses returned immediately → grant order 0,1,2,3,0; no entry is granted twice while outstanding.
- Backpressure: chi_req_ready low 5 cycles → paddr/txnid stable, no further entry_req_ready. Ready high → next grant the same cycle.
- Response routing: outstanding {1,3}, resp txnid=3 data 0xA5.. → entry_resp_valid=4'b1000, data broadcast. txnid=0 → no delivery, resp_err one cycle later.
- Refill: rdy2refill=4'b0110, refill_ready high → grants 0010 then 0100 on consecutive cycles. refill_ready low → no grant.
- Reset asserted with stage full and two outstanding → all outputs 0 immediately, pointers 0 after release.
